// File: rtl/sub_bytes_seq.sv
// Sequential SubBytes/SubWord engine: streams one byte per cycle through a shared
// 256x8 S-box ROM (registered address, unregistered data) and reassembles the word.
module sub_bytes_seq #(
  parameter int unsigned BYTES = 16,
  localparam int unsigned W    = 8 * BYTES,
  localparam int unsigned CW   = $clog2(BYTES + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy,
  output logic         sbox_en,
  output logic [7:0]   sbox_addr,
  input  logic [7:0]   sbox_data
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  in_q, in_d;
  logic [W-1:0]  out_q, out_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      in_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_d      = in_q;
    out_d     = out_q;
    sbox_en   = 1'b0;
    sbox_addr = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          in_d    = in_data;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Address byte cnt now; its substitution arrives next cycle as byte cnt-1.
        if (cnt_q < CW'(BYTES)) begin
          sbox_en = 1'b1;
          for (int unsigned k = 0; k < BYTES; k++) begin
            if (cnt_q == CW'(k)) sbox_addr = in_q[W-1-8*k -: 8];
          end
        end
        for (int unsigned k = 0; k < BYTES; k++) begin
          if (cnt_q == CW'(k + 1)) out_d[W-1-8*k -: 8] = sbox_data;
        end
        if (cnt_q == CW'(BYTES)) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_data  = out_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: BYTES=16 and BYTES=4 instances, each with a behavioural
// S-box ROM model (registered address) whose contents come from a GF(2^8) model.
module tb_sub_bytes_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0, busy16, en16;
  logic [127:0] in_data16 = '0, out_data16;
  logic [7:0]   addr16, data16, rom16_q;

  logic         in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0, busy4, en4;
  logic [31:0]  in_data4 = '0, out_data4;
  logic [7:0]   addr4, data4, rom4_q;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int en16_cnt = 0;
  int en4_cnt = 0;
  int en_bad = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254, then the AES affine transform.
  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] inv, base, e;
    inv = 8'h01; base = a; e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_word(input logic [127:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_f(x[8*k +: 8]);
    return r;
  endfunction

  sub_bytes_seq #(.BYTES(16)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .in_data   (in_data16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .out_data  (out_data16),
    .busy      (busy16),
    .sbox_en   (en16),
    .sbox_addr (addr16),
    .sbox_data (data16)
  );

  sub_bytes_seq #(.BYTES(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_data   (in_data4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_data  (out_data4),
    .busy      (busy4),
    .sbox_en   (en4),
    .sbox_addr (addr4),
    .sbox_data (data4)
  );

  // ROM models: address registered on en, data unregistered.
  always @(posedge clk) begin
    if (en16) rom16_q <= addr16;
    if (en4) rom4_q <= addr4;
  end
  assign data16 = sbox_f(rom16_q);
  assign data4  = sbox_f(rom4_q);

  // en counters, plus a tally of en asserted anywhere but RUN (RUN = busy && !out_valid).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (en16) en16_cnt <= en16_cnt + 1;
    if (en4) en4_cnt <= en4_cnt + 1;
    if ((en16 && !(busy16 && !out_valid16)) || (en4 && !(busy4 && !out_valid4)))
      en_bad <= en_bad + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after a posedge with DUT idle.
  task automatic xfer16(input logic [127:0] din, input logic [127:0] exp, input string name,
                        input bit hold_valid, input bit backpress);
    int lat, en0;
    bit bad_ready, bad_hold;
    check({name, " ready at start"}, {127'd0, in_ready16}, 128'd1);
    in_data16   = din;
    in_valid16  = 1'b1;
    out_ready16 = !backpress;
    @(posedge clk);
    #1;
    en0 = en16_cnt;
    if (!hold_valid) in_valid16 = 1'b0;
    lat = 0;
    bad_ready = 1'b0;
    while (!out_valid16 && lat < 100) begin
      if (in_ready16) bad_ready = 1'b1;
      if (hold_valid) in_data16 = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid16 = 1'b0;
    check({name, " latency"}, 128'(lat), 128'd17);
    check({name, " en cycles"}, 128'(en16_cnt - en0), 128'd16);
    check({name, " data"}, out_data16, exp);
    if (backpress) begin
      bad_hold = 1'b0;
      repeat (20) begin
        @(posedge clk);
        #1;
        if (!out_valid16 || out_data16 !== exp || in_ready16 || en16) bad_hold = 1'b1;
      end
      check({name, " hold under backpressure"}, {127'd0, bad_hold}, 128'd0);
      out_ready16 = 1'b1;
    end
    check({name, " no ready while busy"}, {127'd0, bad_ready}, 128'd0);
    @(posedge clk);
    #1;
    check({name, " back to idle"}, {126'd0, out_valid16, in_ready16}, 128'd1);
  endtask

  task automatic xfer4(input logic [31:0] din, input logic [31:0] exp, input string name,
                       output int acc_cyc);
    int lat, en0;
    in_data4   = din;
    in_valid4  = 1'b1;
    out_ready4 = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    en0 = en4_cnt;
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, 128'(lat), 128'd5);
    check({name, " en cycles"}, 128'(en4_cnt - en0), 128'd4);
    check({name, " data"}, {96'd0, out_data4}, {96'd0, exp});
    @(posedge clk);
    #1;
    check({name, " back to idle"}, {126'd0, out_valid4, in_ready4}, 128'd1);
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
    string        name;
  } vec16_t;

  vec16_t v16[3];
  int     acc_a, acc_b;

  initial begin
    v16[0] = '{128'h0, {16{8'h63}}, "zero"};
    v16[1] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808,
               128'hd42711aee0bf98f1b8b45de51e415230, "fips_r1"};
    v16[2] = '{128'h000102030405060708090a0b0c0d0e0f,
               128'h637c777bf26b6fc53001672bfed7ab76, "seq"};

    #1;
    check("reset ctrl16", {123'd0, in_ready16, out_valid16, busy16, en16, |addr16}, 128'h10);
    check("reset data16", out_data16, 128'd0);
    check("reset ctrl4", {123'd0, in_ready4, out_valid4, busy4, en4, |addr4}, 128'h10);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      check({v16[i].name, " model"}, sub_word(v16[i].din), v16[i].exp);
      xfer16(v16[i].din, v16[i].exp, v16[i].name, 1'b0, 1'b0);
    end

    // SubWord pair, second word accepted the cycle after the first handshake.
    xfer4(32'hcf4f3c09, 32'h8a84eb01, "subword_a", acc_a);
    xfer4(32'h7a96b943, sub_word({96'd0, 32'h7a96b943}) & 128'hffffffff, "subword_b", acc_b);
    check("subword throughput", 128'(acc_b - acc_a), 128'd7);

    xfer16(v16[1].din, v16[1].exp, "hold_valid", 1'b1, 1'b0);
    xfer16(v16[0].din, v16[0].exp, "backpressure", 1'b0, 1'b1);

    // Reset at cnt=7 mid-RUN.
    in_data16   = v16[1].din;
    in_valid16  = 1'b1;
    out_ready16 = 1'b1;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrun reset ctrl", {123'd0, in_ready16, out_valid16, busy16, en16, |addr16}, 128'h10);
    check("midrun reset data", out_data16, 128'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    xfer16(v16[2].din, v16[2].exp, "after_reset", 1'b0, 1'b0);

    check("en only in run", 128'(en_bad), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
